// File: rtl/aes_pkg.sv
// Shared types and constants for the AES chip key/plaintext loader.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic ID_KEY          = 1'b1;
  localparam logic ID_TXT          = 1'b0;
  localparam int   BYTES_PER_BLOCK = 16;
  localparam int   DIV_DEFAULT     = 16;

endpackage

// File: rtl/aes_byte_pacer.sv
// Free-running DIV-cycle pacing counter; tick is high on the last count of each period.
module aes_byte_pacer #(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= 8'd0;
    else if (clr)  cnt <= 8'd0;
    else if (en)   cnt <= tick ? 8'd0 : cnt + 8'd1;
  end

endmodule

// File: rtl/aes_load_sched.sv
// Serialises 128-bit key/plaintext blocks into paced bytes for an external AES chip.
// Define AES_LOAD_RR_EN for round-robin arbitration instead of key-over-text priority.
module aes_load_sched
  import aes_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_req,
  input  logic [127:0] key_data,
  output logic         key_ack,
  input  logic         txt_req,
  input  logic [127:0] txt_data,
  output logic         txt_ack,
  output logic         aes_cu,
  output logic         aes_id,
  output logic [7:0]   aes_data,
  output logic         aes_valid,
  output logic         busy
);

  localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_BLOCK - 1);

  state_t       state, state_nxt;
  logic [127:0] shreg;
  logic [3:0]   byte_idx;
  logic         tick;
  logic         win_key;
  logic         any_req;
  logic         emit;

  assign any_req = key_req | txt_req;

`ifdef AES_LOAD_RR_EN
  logic last_srv;

  // On a tie the type not served last wins; reset value "text" lets key go first.
  assign win_key = key_req && (!txt_req || (last_srv == ID_TXT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           last_srv <= ID_TXT;
    else if (state == IDLE && any_req) last_srv <= win_key ? ID_KEY : ID_TXT;
  end
`else
  assign win_key = key_req;
`endif

  aes_byte_pacer #(.DIV(DIV)) u_pacer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE || state == GRANT),
    .en   (state == SEND || state == GAP),
    .tick (tick)
  );

  assign emit   = (state == SEND) && tick;
  assign aes_cu = (state == GRANT) || (state == SEND);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (any_req) state_nxt = GRANT;
      GRANT: state_nxt = SEND;
      SEND:  if (emit && byte_idx == LAST_BYTE) state_nxt = GAP;
      GAP:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The block is captured on the edge into GRANT, so later input changes never reach the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      byte_idx  <= 4'd0;
      aes_id    <= ID_KEY;
      aes_data  <= 8'h00;
      aes_valid <= 1'b0;
      key_ack   <= 1'b0;
      txt_ack   <= 1'b0;
    end else begin
      key_ack <= 1'b0;
      txt_ack <= 1'b0;
      if (state == IDLE && any_req) begin
        shreg    <= win_key ? key_data : txt_data;
        aes_id   <= win_key ? ID_KEY : ID_TXT;
        byte_idx <= 4'd0;
      end
      if (emit) begin
        aes_data  <= shreg[127:120];
        shreg     <= {shreg[119:0], 8'h00};
        aes_valid <= ~aes_valid;
        byte_idx  <= byte_idx + 4'd1;
        if (byte_idx == LAST_BYTE) begin
          key_ack <= (aes_id == ID_KEY);
          txt_ack <= (aes_id == ID_TXT);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_load_sched.sv
// Directed bench for aes_load_sched: instance 0 runs at DIV=16, instance 1 at DIV=2.
module tb_aes_load_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        key_req, txt_req, key_ack, txt_ack;
  logic [1:0]        aes_cu, aes_id, aes_valid, busy;
  logic [1:0][127:0] key_data, txt_data;
  logic [1:0][7:0]   aes_data;

  int n_cmp = 0;
  int n_err = 0;

  aes_load_sched #(.DIV(16)) dut (
    .clk(clk), .rst(rst),
    .key_req(key_req[0]), .key_data(key_data[0]), .key_ack(key_ack[0]),
    .txt_req(txt_req[0]), .txt_data(txt_data[0]), .txt_ack(txt_ack[0]),
    .aes_cu(aes_cu[0]), .aes_id(aes_id[0]), .aes_data(aes_data[0]),
    .aes_valid(aes_valid[0]), .busy(busy[0])
  );

  aes_load_sched #(.DIV(2)) dut2 (
    .clk(clk), .rst(rst),
    .key_req(key_req[1]), .key_data(key_data[1]), .key_ack(key_ack[1]),
    .txt_req(txt_req[1]), .txt_data(txt_data[1]), .txt_ack(txt_ack[1]),
    .aes_cu(aes_cu[1]), .aes_id(aes_id[1]), .aes_data(aes_data[1]),
    .aes_valid(aes_valid[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input int s, input string tag);
    chk(tag, {aes_cu[s], aes_id[s], aes_data[s], aes_valid[s], key_ack[s], txt_ack[s], busy[s]},
        {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  // Follows one frame from GRANT through GAP on instance s.
  task automatic frame(input int s, input logic [127:0] blk, input logic id, input int div,
                       input int drop_at, input int abort_at, input bit scramble,
                       input string tag);
    int   cyc, g, stray;
    logic pv, ok;
    logic [7:0] d;
    stray = 0;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin @(posedge clk); #1; ok = busy[s]; end
    chk({tag, " grant"}, ok, 1'b1);
    if (!ok) return;
    chk({tag, " cu/id"}, {aes_cu[s], aes_id[s]}, {1'b1, id});
    if (scramble) txt_data[s] = {16{8'hFF}};
    pv = aes_valid[s];
    for (int i = 0; i < 16; i++) begin
      cyc = 0;
      ok = 1'b0;
      while (!ok && cyc < 3 * div + 4) begin
        @(posedge clk); #1;
        cyc++;
        ok = (aes_valid[s] != pv);
        if (!ok && (key_ack[s] | txt_ack[s])) stray++;
      end
      chk($sformatf("%s b%0d seen", tag, i), ok, 1'b1);
      if (!ok) return;
      pv = aes_valid[s];
      chk($sformatf("%s b%0d spacing", tag, i), cyc, (i == 0) ? div + 1 : div);
      chk($sformatf("%s b%0d data", tag, i), aes_data[s], blk[127 - 8 * i -: 8]);
      chk($sformatf("%s b%0d ack", tag, i), {key_ack[s], txt_ack[s]},
          (i == 15) ? (id ? 2'b10 : 2'b01) : 2'b00);
      if (i == drop_at) begin
        if (id) key_req[s] = 1'b0;
        else    txt_req[s] = 1'b0;
      end
      if (i == abort_at) begin
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_rst(s, {tag, " abort reset"});
        @(negedge clk); rst = 1'b0;
        return;
      end
    end
    d = aes_data[s];
    @(posedge clk); #1;
    g = 1;
    chk({tag, " ack width"}, {key_ack[s], txt_ack[s]}, 2'b00);
    chk({tag, " gap cu"}, aes_cu[s], 1'b0);
    while (busy[s] && g < div + 4) begin
      @(posedge clk); #1;
      g++;
      if (key_ack[s] | txt_ack[s]) stray++;
    end
    chk({tag, " gap len"}, g, div);
    chk({tag, " gap held"}, {aes_data[s], aes_valid[s]}, {d, pv});
    chk({tag, " stray ack"}, stray, 0);
  endtask

  initial begin
    int   tog;
    logic pv;
    rst = 1'b1;
    key_req = '0; txt_req = '0; key_data = '0; txt_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk_rst(0, "reset dut");
    chk_rst(1, "reset dut2");

    // Idle after reset: nothing moves for 100 cycles.
    tog = 0;
    pv = aes_valid[0];
    repeat (100) begin
      @(posedge clk); #1;
      if (aes_valid[0] != pv) tog++;
      pv = aes_valid[0];
    end
    chk("idle toggles", tog, 0);
    chk_rst(0, "idle outputs");

    // Single key frame.
    @(negedge clk);
    key_data[0] = 128'h000102030405060708090A0B0C0D0E0F;
    key_req[0] = 1'b1;
    frame(0, 128'h000102030405060708090A0B0C0D0E0F, 1'b1, 16, 15, -1, 1'b0, "key");

    // Simultaneous requests; each requester drops on its own ack.
    @(negedge clk);
    key_data[0] = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    txt_data[0] = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
    key_req[0] = 1'b1;
    txt_req[0] = 1'b1;
`ifdef AES_LOAD_RR_EN
    frame(0, 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, 1'b0, 16, 15, -1, 1'b0, "both txt");
    frame(0, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 1'b1, 16, 15, -1, 1'b0, "both key");
`else
    frame(0, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 1'b1, 16, 15, -1, 1'b0, "both key");
    frame(0, 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, 1'b0, 16, 15, -1, 1'b0, "both txt");
`endif

    // Data changed after GRANT and request dropped mid-frame.
    @(negedge clk);
    txt_data[0] = {16{8'h01}};
    txt_req[0] = 1'b1;
    frame(0, {16{8'h01}}, 1'b0, 16, 5, -1, 1'b1, "latch");

    // Reset mid-frame, then restart from byte 0 with the request still held.
    @(negedge clk);
    key_data[0] = 128'h11223344556677889900AABBCCDDEEFF;
    key_req[0] = 1'b1;
    frame(0, 128'h11223344556677889900AABBCCDDEEFF, 1'b1, 16, -1, 8, 1'b0, "abort");
    frame(0, 128'h11223344556677889900AABBCCDDEEFF, 1'b1, 16, 15, -1, 1'b0, "restart");

    // DIV=2 back-to-back text frames.
    @(negedge clk);
    txt_data[1] = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
    txt_req[1] = 1'b1;
    frame(1, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 1'b0, 2, -1, -1, 1'b0, "div2 f1");
    txt_data[1] = 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF;
    frame(1, 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF, 1'b0, 2, 15, -1, 1'b0, "div2 f2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
